// File: rtl/fetch_pkg.sv
// Shared fetch/decode types: branch codes, fetch FSM states, halt word.
// Imported by the fetch unit and the control decoder.
package fetch_pkg;

  typedef enum logic [1:0] {
    BR_NONE  = 2'b00,
    BR_JCND  = 2'b01,
    BR_NJCND = 2'b10,
    BR_JMP   = 2'b11
  } branch_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fetch_state_e;

  localparam logic [8:0] HALT_OP = 9'b111111111;

  // Branch outcome before qualification by instr_valid
  function automatic logic br_taken(
    input branch_e br,
    input logic    cond
  );
    logic t;
    t = 1'b0;
    unique case (br)
      BR_JMP:   t = 1'b1;
      BR_JCND:  t = cond;
      BR_NJCND: t = ~cond;
      default:  t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/instr_fetch_pc.sv
// Program counter register: clear / load / increment.
// Increment wraps silently at 2^PC_W.
module program_counter #(
  parameter int PC_W = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  // clr, load and inc are mutually exclusive by construction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else begin
      unique case (1'b1)
        clr:     pc <= '0;
        load:    pc <= load_val;
        inc:     pc <= pc + PC_W'(1);
        default: pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives imem, feeds the decoder,
// redirects on taken branches, stops on the halt word.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int IW    = 9,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [1:0]       Branch,
  input  logic             cond_flag,
  input  logic [PC_W-1:0]  target,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [IW-1:0]    imem_data,
  output logic [IW-1:0]    instr,
  output logic             instr_valid,
  output logic [PC_W-1:0]  pc_of_instr,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  fetch_state_e    state;
  logic [PC_W-1:0] pc;
  logic            run;
  logic            halt;
  logic            taken;
  logic            pc_clr;
  logic            pc_load;
  logic            pc_inc;

  assign run   = (state == RUN);
  assign halt  = instr_valid && (instr == IW'(HALT_OP));
  assign taken = instr_valid
               && br_taken(branch_e'(Branch), cond_flag);

  assign pc_clr  = start && !run;
  assign pc_load = run && !halt && taken;
  assign pc_inc  = run && !halt && !taken;

  assign imem_addr = (state == IDLE) ? '0 : pc;

  program_counter #(
    .PC_W (PC_W)
  ) u_pc (
    .clk      (Clk),
    .rst      (Reset),
    .clr      (pc_clr),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (target),
    .pc       (pc)
  );

  // Fetch FSM, instruction register, squash and cycle counter
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      instr       <= '0;
      instr_valid <= 1'b0;
      pc_of_instr <= '0;
      done        <= 1'b0;
      cycle_count <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          instr_valid <= 1'b0;
          if (start) begin
            state       <= RUN;
            done        <= 1'b0;
            cycle_count <= '0;
          end
        end
        RUN: begin
          instr       <= imem_data;
          pc_of_instr <= pc;
          if (cycle_count != '1)
            cycle_count <= cycle_count + CNT_W'(1);
          if (halt) begin
            state       <= DONE;
            done        <= 1'b1;
            instr_valid <= 1'b0;
          end else begin
            instr_valid <= !taken;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, branches,
// halt, mid-run reset, and a small PC/counter wrap instance.
module tb_instr_fetch;

  localparam logic [8:0] HLT = 9'h1FF;
  localparam logic [8:0] ALU = 9'h001;
  localparam int BUB = 999;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic        cond = 1'b0;
  logic [1:0]  Branch;
  logic [9:0]  target;
  logic [9:0]  imem_addr;
  logic [8:0]  imem_data;
  logic [8:0]  instr;
  logic        instr_valid;
  logic [9:0]  pc_of_instr;
  logic        done;
  logic [15:0] cycle_count;

  logic        start2 = 1'b0;
  logic [3:0]  imem_addr2;
  logic [8:0]  instr2;
  logic        instr_valid2;
  logic [3:0]  pc_of_instr2;
  logic        done2;
  logic [3:0]  cycle_count2;

  logic [8:0] mem    [0:1023];
  logic [1:0] br_tab [0:1023];
  logic [9:0] tgt_tab[0:1023];

  int ncmp = 0;
  int nerr = 0;
  int trace[$];
  int exp_q[$];

  always #5 Clk = ~Clk;

  assign imem_data = mem[imem_addr];
  assign Branch    = br_tab[pc_of_instr];
  assign target    = tgt_tab[pc_of_instr];

  instr_fetch u_dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .start       (start),
    .Branch      (Branch),
    .cond_flag   (cond),
    .target      (target),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc_of_instr (pc_of_instr),
    .done        (done),
    .cycle_count (cycle_count)
  );

  instr_fetch #(
    .PC_W  (4),
    .IW    (9),
    .CNT_W (4)
  ) u_small (
    .Clk         (Clk),
    .Reset       (Reset),
    .start       (start2),
    .Branch      (2'b00),
    .cond_flag   (1'b0),
    .target      (4'd0),
    .imem_addr   (imem_addr2),
    .imem_data   (ALU),
    .instr       (instr2),
    .instr_valid (instr_valid2),
    .pc_of_instr (pc_of_instr2),
    .done        (done2),
    .cycle_count (cycle_count2)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = ALU;
      br_tab[i]  = 2'b00;
      tgt_tab[i] = 10'd0;
    end
  endtask

  // One program run; logs pc_of_instr per cycle, BUB for bubbles
  task automatic run_prog(
    input  int budget,
    input  bit mid_start,
    input  bit halt_start,
    output int ncyc
  );
    trace.delete();
    ncyc  = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("c1_valid", instr_valid, 0);
    for (int k = 2; k <= budget; k++) begin
      tick();
      start = 1'b0;
      if (done) begin
        ncyc = k;
        break;
      end
      if (instr_valid) trace.push_back(int'(pc_of_instr));
      else trace.push_back(BUB);
      if (mid_start && k == 3) start = 1'b1;
      if (halt_start && instr_valid && instr == HLT) start = 1'b1;
    end
    if (ncyc == 0) chk("timeout", 0, 1);
  endtask

  task automatic check_trace(input string tag);
    chk({tag, "_len"}, trace.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < trace.size(); i++)
      chk($sformatf("%s_%0d", tag, i), trace[i], exp_q[i]);
  endtask

  int n;
  int bubbles;

  initial begin
    clear_prog();
    tick();
    chk("rst_valid", instr_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", cycle_count, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_instr", instr, 0);
    Reset = 1'b0;
    tick();

    // straight line, halt at 4
    mem[4] = HLT;
    run_prog(50, 1'b1, 1'b0, n);
    exp_q = '{0, 1, 2, 3, 4};
    check_trace("t1");
    chk("t1_done_cyc", n, 7);
    chk("t1_cnt", cycle_count, 6);
    repeat (3) tick();
    chk("t1_cnt_hold", cycle_count, 6);
    chk("t1_done_hold", done, 1);
    chk("t1_valid_off", instr_valid, 0);

    // jmp at 2 -> 8; squashed slot carries an ignored jmp
    clear_prog();
    br_tab[2] = 2'b11; tgt_tab[2] = 10'd8;
    br_tab[3] = 2'b11; tgt_tab[3] = 10'd20;
    mem[10] = HLT;
    run_prog(50, 1'b0, 1'b0, n);
    exp_q = '{0, 1, 2, BUB, 8, 9, 10};
    check_trace("t2");

    // jcnd / !jcnd at 5 -> 12
    clear_prog();
    mem[7] = HLT; mem[13] = HLT;
    br_tab[5] = 2'b01; tgt_tab[5] = 10'd12;
    cond = 1'b0;
    run_prog(50, 1'b0, 1'b0, n);
    exp_q = '{0, 1, 2, 3, 4, 5, 6, 7};
    check_trace("t3a");
    cond = 1'b1;
    run_prog(50, 1'b1, 1'b0, n);
    exp_q = '{0, 1, 2, 3, 4, 5, BUB, 12, 13};
    check_trace("t3b");
    br_tab[5] = 2'b10;
    cond = 1'b0;
    run_prog(50, 1'b0, 1'b0, n);
    check_trace("t3c");
    cond = 1'b1;
    run_prog(50, 1'b0, 1'b0, n);
    exp_q = '{0, 1, 2, 3, 4, 5, 6, 7};
    check_trace("t3d");
    cond = 1'b0;

    // halt with jmp presented, start in the halt cycle
    clear_prog();
    mem[3] = HLT;
    br_tab[3] = 2'b11; tgt_tab[3] = 10'd9;
    run_prog(50, 1'b0, 1'b1, n);
    exp_q = '{0, 1, 2, 3};
    check_trace("t4");
    repeat (3) tick();
    chk("t4_done", done, 1);
    chk("t4_valid", instr_valid, 0);
    chk("t4_addr", imem_addr, 4);
    chk("t4_cnt", cycle_count, 5);
    run_prog(50, 1'b0, 1'b0, n);
    check_trace("t4r");

    // back-to-back taken branches: 1 -> 6, 6 -> 9
    clear_prog();
    br_tab[1] = 2'b11; tgt_tab[1] = 10'd6;
    br_tab[6] = 2'b11; tgt_tab[6] = 10'd9;
    mem[10] = HLT;
    run_prog(50, 1'b0, 1'b0, n);
    exp_q = '{0, 1, BUB, 6, BUB, 9, 10};
    check_trace("b2b");

    // mid-run reset
    clear_prog();
    mem[4] = HLT;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    Reset = 1'b1;
    #1;
    chk("mr_valid", instr_valid, 0);
    chk("mr_pcof", pc_of_instr, 0);
    chk("mr_cnt", cycle_count, 0);
    chk("mr_addr", imem_addr, 0);
    chk("mr_instr", instr, 0);
    start = 1'b1;
    repeat (2) tick();
    chk("mr_hold_cnt", cycle_count, 0);
    chk("mr_hold_addr", imem_addr, 0);
    chk("mr_hold_done", done, 0);
    start = 1'b0;
    Reset = 1'b0;
    tick();
    run_prog(50, 1'b0, 1'b0, n);
    exp_q = '{0, 1, 2, 3, 4};
    check_trace("mr");
    chk("mr_cnt_end", cycle_count, 6);

    // small instance: PC wrap and counter saturation
    bubbles = 0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int c = 2; c <= 20; c++) begin
      tick();
      if (!instr_valid2) bubbles++;
      if (c == 15) chk("w_cnt15", cycle_count2, 14);
      if (c == 17) chk("w_pc17", pc_of_instr2, 15);
      if (c == 18) chk("w_pc18", pc_of_instr2, 0);
      if (c == 20) chk("w_cnt20", cycle_count2, 15);
    end
    chk("w_bubbles", bubbles, 0);
    chk("w_done", done2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
